multicycle_sequencer: RTL



---
 rtl/cpu_pkg.sv | 45 ++++
 rtl/multicycle_sequencer_mem_watchdog.sv | 38 +++
 rtl/multicycle_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle control path: opcodes, FSM states,
// PC source selects and ALU function codes.
package cpu_pkg;

    localparam logic [3:0] OP_ADDI = 4'd8;
    localparam logic [3:0] OP_LW   = 4'd9;
    localparam logic [3:0] OP_SW   = 4'd10;
    localparam logic [3:0] OP_BEQ  = 4'd11;
    localparam logic [3:0] OP_JMP  = 4'd12;
    localparam logic [3:0] OP_NOP0 = 4'd13;
    localparam logic [3:0] OP_NOP1 = 4'd14;
    localparam logic [3:0] OP_HALT = 4'd15;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        PC_PLUS1  = 2'b00,
        PC_BRANCH = 2'b01,
        PC_JUMP   = 2'b10
    } pc_src_t;

    // R-type opcodes pass straight through as the ALU function; BEQ compares by subtraction.
    function automatic logic [3:0] alu_op_for(input logic [3:0] op);
        if (!op[3]) begin
            return op;
        end
        if (op == OP_BEQ) begin
            return ALU_SUB;
        end
        return ALU_ADD;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_watchdog.sv
// Counts unanswered memory-request cycles; flags a timeout and latches a sticky bus error.
module mem_watchdog #(
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNTW        = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic busy,
    input  logic mem_ready,
    output logic timeout_c,
    output logic bus_err
);

    logic [CNTW-1:0] cnt_q;
    logic            stall;

    assign stall     = busy && !mem_ready;
    // The MEM_TIMEOUT-th stalled cycle is the last chance; ready on it still succeeds.
    assign timeout_c = stall && (cnt_q == CNTW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            bus_err <= 1'b0;
        end else begin
            if (clear) begin
                cnt_q <= '0;
            end else if (stall && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNTW'(1);
            end
            if (timeout_c) begin
                bus_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with a shared memory port
// and a watchdog that turns a hung access into a sticky bus error.
module multicycle_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned OPW         = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNTW        = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           run,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           mem_we,
    output logic           mem_addr_sel,
    output logic           ir_write,
    output logic           pc_write,
    output logic [1:0]     pc_src,
    output logic [3:0]     ALU_op,
    output logic           ALU_src,
    output logic           reg_write,
    output logic           reg_dst,
    output logic           mem_reg,
    output logic           retire,
    output logic           bus_err,
    output logic [2:0]     state
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] op;
    logic       is_ls;
    logic       use_imm;
    logic       mem_busy;
    logic       wd_clear;
    logic       timeout_c;

    assign op      = 4'(opcode);
    assign is_ls   = (op == OP_LW) || (op == OP_SW);
    assign use_imm = (op == OP_ADDI) || is_ls;
    assign state   = state_q;

    assign mem_busy = (state_q == ST_FETCH) || (state_q == ST_MEM);
    assign wd_clear = ((state_d == ST_FETCH) || (state_d == ST_MEM)) && (state_d != state_q);

    mem_watchdog #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNTW        (CNTW)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clear     (wd_clear),
        .busy      (mem_busy),
        .mem_ready (mem_ready),
        .timeout_c (timeout_c),
        .bus_err   (bus_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = PC_PLUS1;
        ALU_op       = ALU_ADD;
        ALU_src      = 1'b0;
        reg_write    = 1'b0;
        reg_dst      = 1'b0;
        mem_reg      = 1'b0;
        retire       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_PLUS1;
                    state_d  = ST_DECODE;
                end else if (timeout_c) begin
                    state_d = ST_ERR;
                end
            end
            ST_DECODE: begin
                case (op)
                    OP_HALT: state_d = ST_HALT;
                    OP_JMP: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                        retire   = 1'b1;
                    end
                    OP_NOP0, OP_NOP1: retire = 1'b1;
                    default: state_d = ST_EXEC;
                endcase
            end
            ST_EXEC: begin
                ALU_op  = alu_op_for(op);
                ALU_src = use_imm;
                if (op == OP_BEQ) begin
                    pc_write = zero;
                    pc_src   = zero ? PC_BRANCH : PC_PLUS1;
                    retire   = 1'b1;
                end else if (is_ls) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = (op == OP_SW);
                ALU_op       = alu_op_for(op);
                ALU_src      = use_imm;
                if (mem_ready) begin
                    if (op == OP_SW) begin
                        retire = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (timeout_c) begin
                    state_d = ST_ERR;
                end
            end
            ST_WB: begin
                reg_write = 1'b1;
                reg_dst   = !op[3];
                mem_reg   = (op == OP_LW);
                retire    = 1'b1;
            end
            ST_HALT, ST_ERR: begin
                state_d = state_q;
            end
            default: state_d = ST_IDLE;
        endcase

        if (retire) begin
            state_d = run ? ST_FETCH : ST_IDLE;
        end

        // Reset mid-instruction must not let any strobe commit in that cycle.
        if (rst) begin
            state_d      = ST_IDLE;
            mem_req      = 1'b0;
            mem_we       = 1'b0;
            mem_addr_sel = 1'b0;
            ir_write     = 1'b0;
            pc_write     = 1'b0;
            pc_src       = PC_PLUS1;
            ALU_op       = ALU_ADD;
            ALU_src      = 1'b0;
            reg_write    = 1'b0;
            reg_dst      = 1'b0;
            mem_reg      = 1'b0;
            retire       = 1'b0;
        end
    end

endmodule
